// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst-read sequencer: peripheral register map,
// control/status bit constants and the state encodings.
package i2c_pkg;

    localparam logic [3:0] REG_PRERL = 4'd0;
    localparam logic [3:0] REG_PRERH = 4'd1;
    localparam logic [3:0] REG_CTR   = 4'd2;
    localparam logic [3:0] REG_TXR   = 4'd3;
    localparam logic [3:0] REG_RXR   = 4'd3;
    localparam logic [3:0] REG_CR    = 4'd4;
    localparam logic [3:0] REG_SR    = 4'd4;

    localparam logic [7:0] CR_STA = 8'h80;
    localparam logic [7:0] CR_STO = 8'h40;
    localparam logic [7:0] CR_RD  = 8'h20;
    localparam logic [7:0] CR_WR  = 8'h10;
    localparam logic [7:0] CR_ACK = 8'h08;
    localparam logic [7:0] CTR_EN = 8'h80;

    localparam int SR_RXACK = 7;
    localparam int SR_TIP   = 1;

    typedef enum logic [3:0] {
        ST_PRERL, ST_PRERH, ST_CTR, ST_IDLE, ST_TXR,
        ST_CMD, ST_POLL, ST_RXR, ST_DONE, ST_STOP
    } seq_state_t;

    typedef enum logic [1:0] {PH_WADDR, PH_REG, PH_RADDR, PH_DATA} phase_t;

    typedef enum logic [1:0] {OP_WR, OP_RD, OP_POLL} bus_op_t;

    typedef enum logic [1:0] {B_IDLE, B_ACC, B_SAMP, B_GAP} bus_state_t;

endpackage

// File: rtl/i2c_seq_busif.sv
// Bus access engine: issues one single-cycle access per request, samples read
// data one cycle later, and runs status polling with a saturating timeout.
module i2c_seq_busif
    import i2c_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  bus_op_t     op,
    input  logic [3:0]  addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic        tmo,
    output logic [7:0]  rdata,
    output logic        m_cs,
    output logic        m_wr,
    output logic        m_rd,
    output logic [3:0]  m_addr,
    output logic [15:0] m_dout,
    input  logic [15:0] m_din
);

    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

    bus_state_t  state_q, state_d;
    bus_op_t     op_q;
    logic [3:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [15:0] tcnt_q;
    logic        tip;
    logic [7:0]  unused_din_hi;

    assign tip           = m_din[SR_TIP];
    assign rdata         = m_din[7:0];
    assign unused_din_hi = m_din[15:8];

    // tcnt counts every cycle spent in a poll so a stuck TIP is bounded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= B_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == B_IDLE && req)
                tcnt_q <= '0;
            else if (state_q != B_IDLE && op_q == OP_POLL && tcnt_q != '1)
                tcnt_q <= tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == B_IDLE && req) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        ack     = 1'b0;
        tmo     = 1'b0;
        m_cs    = 1'b0;
        m_wr    = 1'b0;
        m_rd    = 1'b0;
        m_addr  = '0;
        m_dout  = '0;
        case (state_q)
            B_IDLE: if (req) state_d = B_ACC;
            B_ACC: begin
                m_cs   = 1'b1;
                m_addr = addr_q;
                if (op_q == OP_WR) begin
                    m_wr    = 1'b1;
                    m_dout  = {8'h00, wdata_q};
                    state_d = B_GAP;
                end else begin
                    m_rd    = 1'b1;
                    state_d = B_SAMP;
                end
            end
            B_SAMP: begin
                if (op_q == OP_RD || !tip) begin
                    ack     = 1'b1;
                    state_d = B_IDLE;
                end else if (tcnt_q >= TMO_LIM) begin
                    tmo     = 1'b1;
                    state_d = B_IDLE;
                end else begin
                    state_d = B_ACC;
                end
            end
            B_GAP: begin
                ack     = 1'b1;
                state_d = B_IDLE;
            end
            default: state_d = B_IDLE;
        endcase
    end

endmodule

// File: rtl/i2c_mpu_seq.sv
// Burst-read sequencer driving a peripheral_i2c master: init after reset, then
// one addressed register burst read per start. Optional I2C_SEQ_WORD16_EN pairs bytes into words.
module i2c_mpu_seq
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR7 = 7'h69,
    parameter logic [15:0] PRESCALE    = 16'h09E5,
    parameter logic [7:0]  REG_ADDR    = 8'h3B,
    parameter int          NBYTES      = 6,
    parameter int          TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        m_cs,
    output logic        m_wr,
    output logic        m_rd,
    output logic [3:0]  m_addr,
    output logic [15:0] m_dout,
    input  logic [15:0] m_din
`ifdef I2C_SEQ_WORD16_EN
    ,
    output logic [15:0] word_data,
    output logic        word_valid
`endif
);

    localparam logic [7:0] WADDR = {SLAVE_ADDR7, 1'b0};
    localparam logic [7:0] RADDR = {SLAVE_ADDR7, 1'b1};
    localparam logic [3:0] LAST  = 4'(NBYTES - 1);

    seq_state_t state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [3:0] cnt_q, cnt_d;
    logic       issued_q, issued_d;
    logic       cmd, req, ack, tmo;
    bus_op_t    op;
    logic [3:0] addr;
    logic [7:0] wdata, bus_rdata;
    logic       vld_p0, done_p0, err_p0;

    i2c_seq_busif #(.TIMEOUT(TIMEOUT)) u_busif (
        .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ack(ack), .tmo(tmo), .rdata(bus_rdata),
        .m_cs(m_cs), .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr),
        .m_dout(m_dout), .m_din(m_din)
    );

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_PRERL;
            phase_q  <= PH_WADDR;
            cnt_q    <= '0;
            issued_q <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            issued_q <= issued_d;
            rd_valid <= vld_p0;
            done     <= done_p0;
            err      <= err_p0;
            if (vld_p0) rd_data <= bus_rdata;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        cmd     = 1'b0;
        op      = OP_WR;
        addr    = '0;
        wdata   = '0;
        vld_p0  = 1'b0;
        done_p0 = 1'b0;
        err_p0  = 1'b0;
        case (state_q)
            ST_PRERL: begin
                cmd = 1'b1; addr = REG_PRERL; wdata = PRESCALE[7:0];
                if (ack) state_d = ST_PRERH;
            end
            ST_PRERH: begin
                cmd = 1'b1; addr = REG_PRERH; wdata = PRESCALE[15:8];
                if (ack) state_d = ST_CTR;
            end
            ST_CTR: begin
                cmd = 1'b1; addr = REG_CTR; wdata = CTR_EN;
                if (ack) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_TXR;
                    phase_d = PH_WADDR;
                    cnt_d   = '0;
                end
            end
            ST_TXR: begin
                cmd  = 1'b1;
                addr = REG_TXR;
                case (phase_q)
                    PH_WADDR: wdata = WADDR;
                    PH_REG:   wdata = REG_ADDR;
                    default:  wdata = RADDR;
                endcase
                if (ack) state_d = ST_CMD;
            end
            ST_CMD: begin
                cmd  = 1'b1;
                addr = REG_CR;
                case (phase_q)
                    PH_REG:  wdata = CR_WR;
                    PH_DATA: wdata = (cnt_q == LAST) ? (CR_RD | CR_STO | CR_ACK) : CR_RD;
                    default: wdata = CR_STA | CR_WR;
                endcase
                if (ack) state_d = ST_POLL;
            end
            ST_POLL: begin
                cmd  = 1'b1;
                op   = OP_POLL;
                addr = REG_SR;
                if (tmo) begin
                    state_d = ST_STOP;
                end else if (ack) begin
                    // address/register phases abort on NACK; data bytes are master-acked
                    if (phase_q != PH_DATA && bus_rdata[SR_RXACK]) begin
                        state_d = ST_STOP;
                    end else begin
                        case (phase_q)
                            PH_WADDR: begin phase_d = PH_REG;   state_d = ST_TXR; end
                            PH_REG:   begin phase_d = PH_RADDR; state_d = ST_TXR; end
                            PH_RADDR: begin phase_d = PH_DATA;  state_d = ST_CMD; end
                            default:  state_d = ST_RXR;
                        endcase
                    end
                end
            end
            ST_RXR: begin
                cmd  = 1'b1;
                op   = OP_RD;
                addr = REG_RXR;
                if (ack) begin
                    vld_p0 = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ST_CMD;
                    end
                end
            end
            ST_DONE: begin
                done_p0 = 1'b1;
                state_d = ST_IDLE;
            end
            ST_STOP: begin
                cmd = 1'b1; addr = REG_CR; wdata = CR_STO;
                if (ack) begin
                    err_p0  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_PRERL;
        endcase
        // each command state issues exactly one request, then waits for ack/tmo
        req      = cmd && !issued_q;
        issued_d = (state_d == state_q) ? (issued_q | req) : 1'b0;
    end

`ifdef I2C_SEQ_WORD16_EN
    logic [7:0] hi_q;
    logic       half_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q     <= 1'b0;
            word_valid <= 1'b0;
            word_data  <= '0;
        end else begin
            word_valid <= 1'b0;
            if (state_q == ST_IDLE) begin
                half_q <= 1'b0;
            end else if (vld_p0) begin
                if (half_q) begin
                    word_data  <= {hi_q, bus_rdata};
                    word_valid <= 1'b1;
                end
                half_q <= ~half_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p0 && !half_q) hi_q <= bus_rdata;
    end
`endif

endmodule

// File: tb/tb_i2c_mpu_seq.sv
// Scoreboard bench for i2c_mpu_seq with a behavioural peripheral_i2c register model.
module tb_i2c_mpu_seq;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        busy, done, err, rd_valid;
    logic [7:0]  rd_data;
    logic        m_cs, m_wr, m_rd;
    logic [3:0]  m_addr;
    logic [15:0] m_dout;
    logic [15:0] m_din = 16'hA5A5;
`ifdef I2C_SEQ_WORD16_EN
    logic [15:0] word_data;
    logic        word_valid;
`endif

    always #5 clk = ~clk;

    i2c_mpu_seq #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .rd_data(rd_data), .rd_valid(rd_valid), .m_cs(m_cs), .m_wr(m_wr),
        .m_rd(m_rd), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
`ifdef I2C_SEQ_WORD16_EN
        , .word_data(word_data), .word_valid(word_valid)
`endif
    );

    // peripheral model: registered read data, garbage outside the sample cycle
    int         sr_mode = 0;
    logic [7:0] rx_mem [16];
    logic [3:0] rx_idx = '0;
    int         sr_reads = 0;
    int         rx_reads = 0;
    logic       rx_rewind = 1'b0;

    always @(posedge clk) begin
        if (rx_rewind) rx_idx <= '0;
        if (m_cs && m_rd && m_addr == 4'd4) begin
            sr_reads <= sr_reads + 1;
            m_din <= (sr_mode == 1) ? 16'h0080 : (sr_mode == 2) ? 16'h0002 : 16'h0000;
        end else if (m_cs && m_rd && m_addr == 4'd3) begin
            rx_reads <= rx_reads + 1;
            m_din  <= {8'h00, rx_mem[rx_idx]};
            rx_idx <= rx_idx + 4'd1;
        end else begin
            m_din <= 16'hA5A5;
        end
    end

    int n_vec = 0, n_bad = 0;
    int cyc = 0, viol = 0, rv_cnt = 0, done_cnt = 0, err_cnt = 0, word_cnt = 0, extra = 0;
    int last_rv = 0, done_cyc = 0;
    logic        prev_cs = 1'b0;
    logic [7:0]  exp_q[$];
    logic [15:0] wexp_q[$];
    logic [11:0] wr_log[$];
    logic [11:0] exp_wr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (m_cs && m_wr) wr_log.push_back({m_addr, m_dout[7:0]});
            if (m_cs && (m_wr == m_rd)) viol++;
            if (!m_cs && (m_wr || m_rd)) viol++;
            if (m_cs && m_wr && m_dout[15:8] != 8'h00) viol++;
            if (m_cs && prev_cs) viol++;
            prev_cs = m_cs;
            if (rd_valid) begin
                rv_cnt++;
                last_rv = cyc;
                if (exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
                else extra++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err) err_cnt++;
`ifdef I2C_SEQ_WORD16_EN
            if (word_valid) begin
                word_cnt++;
                if (wexp_q.size() > 0) check("word_data", word_data, wexp_q.pop_front());
                else extra++;
            end
`endif
        end
    endtask

    task automatic clear_stats();
        rv_cnt = 0; done_cnt = 0; err_cnt = 0; word_cnt = 0; extra = 0;
        wr_log.delete(); exp_q.delete(); wexp_q.delete(); exp_wr.delete();
    endtask

    task automatic load_rx(input logic [7:0] first, input logic [7:0] step);
        for (int i = 0; i < 16; i++) rx_mem[i] = first + 8'(i) * step;
        rx_rewind = 1'b1;
        @(negedge clk);
        rx_rewind = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", busy, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy && n < budget) begin @(negedge clk); n++; end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < budget) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("end_in_budget", 32'(n < budget), 1);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
    endtask

    task automatic exp_burst_log();
        exp_wr = '{12'h3D2, 12'h490, 12'h33B, 12'h410, 12'h3D3, 12'h490};
        for (int i = 0; i < 5; i++) exp_wr.push_back(12'h420);
        exp_wr.push_back(12'h468);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_flags"}, {done, err, rd_valid}, 3'b000);
        check({tag, "_rd_data"}, rd_data, 8'h00);
        check({tag, "_strobes"}, {m_cs, m_wr, m_rd, m_addr, m_dout}, 23'h0);
    endtask

    task automatic good_burst(input string tag, input logic [7:0] first);
        int rx0;
        load_rx(first, 8'h01);
        clear_stats();
        for (int i = 0; i < 6; i++) exp_q.push_back(first + 8'(i));
        rx0 = rx_reads;
        do_start();
        wait_end(3000);
        check({tag, "_done"}, done_cnt, 1);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_nvalid"}, rv_cnt, 6);
        check({tag, "_sb_left"}, exp_q.size() + extra, 0);
        check({tag, "_done_after_last"}, done_cyc, last_rv + 1);
        check({tag, "_rx_reads"}, rx_reads - rx0, 6);
        check({tag, "_idle"}, busy, 1'b0);
        exp_burst_log();
        check_log(tag);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sr0, n;
        rst = 1'b1; start = 1'b0;
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        reset_checks("rst");
        start = 1'b1;
        @(negedge clk);
        clear_stats();
        rst = 1'b0;
        wait_idle("init_idle", 200);
        start = 1'b0;
        exp_wr = '{12'h0E5, 12'h109, 12'h280};
        check_log("init");
        check("init_no_burst", rv_cnt + done_cnt + err_cnt, 0);

        // normal burst, plus a start while busy that must be ignored
        load_rx(8'h01, 8'h01);
        clear_stats();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'(i + 1));
        do_start();
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_end(3000);
        repeat (200) @(negedge clk);
        check("burst_done", done_cnt, 1);
        check("burst_err", err_cnt, 0);
        check("burst_nvalid", rv_cnt, 6);
        check("burst_sb_left", exp_q.size() + extra, 0);
        check("burst_done_after_last", done_cyc, last_rv + 1);
        exp_burst_log();
        check_log("burst");

        // address NACK
        sr_mode = 1;
        clear_stats();
        do_start();
        wait_end(3000);
        check("nack_err", err_cnt, 1);
        check("nack_done", done_cnt, 0);
        check("nack_nvalid", rv_cnt, 0);
        check("nack_idle", busy, 1'b0);
        exp_wr = '{12'h3D2, 12'h490, 12'h440};
        check_log("nack");

        // TIP stuck high: timeout after TIMEOUT+1 poll cycles
        sr_mode = 2;
        clear_stats();
        sr0 = sr_reads;
        do_start();
        wait_end(3000);
        check("tmo_err", err_cnt, 1);
        check("tmo_done", done_cnt, 0);
        check("tmo_sr_reads", sr_reads - sr0, (TMO + 2) / 2);
        check("tmo_idle", busy, 1'b0);
        exp_wr = '{12'h3D2, 12'h490, 12'h440};
        check_log("tmo");
        sr_mode = 0;

        // reset during the third byte: no stop command, init re-runs
        load_rx(8'h40, 8'h01);
        clear_stats();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h40 + 8'(i));
        do_start();
        n = 0;
        while (rv_cnt < 2 && n < 2000) begin @(negedge clk); n++; end
        check("mid_reached_byte3", rv_cnt, 2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        reset_checks("mid_rst");
        clear_stats();
        rst = 1'b0;
        wait_idle("mid_init_idle", 200);
        exp_wr = '{12'h0E5, 12'h109, 12'h280};
        check_log("mid_init");
        good_burst("after_rst", 8'h70);

`ifdef I2C_SEQ_WORD16_EN
        load_rx(8'h12, 8'h22);
        clear_stats();
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h12 + 8'(i) * 8'h22);
        wexp_q = '{16'h1234, 16'h5678, 16'h9ABC};
        do_start();
        wait_end(3000);
        check("word_cnt", word_cnt, 3);
        check("word_sb_left", wexp_q.size() + exp_q.size() + extra, 0);
`endif

        check("bus_protocol", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_mpu_seq.md
I2C_MPU_SEQ -- requirements
Module: i2c_mpu_seq

Interface
REQ-001 SHALL have parameter SLAVE_ADDR7, default 7'h69, the 7-bit target address (write byte 8'hD2, read byte 8'hD3).
REQ-002 SHALL have parameter PRESCALE, default 16'h09E5, the prescaler value written to prerh:prerl.
REQ-003 SHALL have parameter REG_ADDR, default 8'h3B, the first target register read.
REQ-004 SHALL have parameter NBYTES, default 6, the burst length (range 1..15).
REQ-005 SHALL have parameter TIMEOUT, default 65535, the maximum poll cycles per transfer.
REQ-006 clk  in  1  system clock; one clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  one-cycle request to run one burst read.
REQ-009 busy  out  1  high from accepted start until done/err.
REQ-010 done  out  1  one-cycle pulse, burst completed.
REQ-011 err  out  1  one-cycle pulse, NACK or timeout abort.
REQ-012 rd_data  out  8  received byte.
REQ-013 rd_valid  out  1  one-cycle strobe qualifying rd_data.
REQ-014 m_cs, m_wr, m_rd  out  1 each  bus strobes to peripheral_i2c.
REQ-015 m_addr  out  4  peripheral register address.
REQ-016 m_dout  out  16  write data (peripheral d_in); upper byte always 8'h00.
REQ-017 m_din  in  16  read data (peripheral d_out); bits [7:0] used.

Function
REQ-018 Each bus access SHALL be one cycle with m_cs=1 and exactly one of m_wr/m_rd=1; all strobes 0 otherwise; at most one access per 2 cycles.
REQ-019 Read data SHALL be sampled on m_din exactly one cycle after the m_rd cycle.
REQ-020 Peripheral map: 0 prerl, 1 prerh, 2 ctr, 3 txr(wr)/rxr(rd), 4 cr(wr)/sr(rd); CR bits STA=0x80, STO=0x40, RD=0x20, WR=0x10, ACK=0x08; SR bits RxACK=bit7, TIP=bit1.
REQ-021 After reset, SHALL run INIT automatically: prerl=PRESCALE[7:0], prerh=PRESCALE[15:8], ctr=0x80; busy=1 during INIT; start ignored until INIT ends.
REQ-022 In IDLE, start=1 SHALL move to transfer with busy=1 the next cycle; start while busy SHALL be ignored.
REQ-023 Sequence: txr=0xD2, cr=0x90, POLL; txr=REG_ADDR, cr=0x10, POLL; txr=0xD3, cr=0x90, POLL; per byte cr=0x20 (last byte 0x68), POLL, read rxr, emit.
REQ-024 POLL SHALL read sr repeatedly until TIP=0; after each address/register phase, RxACK=1 SHALL abort.
REQ-025 Abort (NACK or POLL exceeding TIMEOUT cycles) SHALL write cr=0x40, pulse err, return to IDLE; done SHALL NOT pulse.
REQ-026 rd_valid SHALL pulse once per byte, in order, NBYTES total; done SHALL pulse the cycle after the last rd_valid.
REQ-027 Timeout counter SHALL reset at each POLL entry and saturate, never wrap.

Reset
REQ-028 rst SHALL force: state=INIT start, busy=1, done=0, err=0, rd_valid=0, rd_data=0, all m_* outputs 0, counters 0.
REQ-029 rst mid-burst SHALL abandon the burst immediately without a stop command; INIT SHALL re-run.

Configuration
REQ-030 With I2C_SEQ_WORD16_EN defined, SHALL add outputs word_data[15:0] and word_valid: bytes paired big-endian (first byte high), word_valid pulsing with the second byte's rd_valid; odd final byte discarded.
REQ-031 Without I2C_SEQ_WORD16_EN, those ports and logic SHALL be absent; byte behaviour unchanged.

Structure
REQ-032 Package i2c_pkg SHALL hold register addresses, CR/SR bit constants and the state enum.
REQ-033 Sub-module i2c_seq_busif SHALL own single access issue, read-sample timing and POLL/timeout; i2c_mpu_seq owns sequencing.

Verification
REQ-034 Reset release -> writes to addr 0 (0xE5), 1 (0x09), 2 (0x80) in order, then busy=0.
REQ-035 start, slave model ACKs, returns 0x01..0x06 -> six rd_valid with 0x01..0x06, then done; last cr write 0x68.
REQ-036 Slave NACKs address (sr=0x80 with TIP=0) -> cr=0x40 written, err pulse, no rd_valid, busy=0.
REQ-037 sr TIP held 1 -> err after TIMEOUT+1 poll cycles (TIMEOUT=100 bench override).
REQ-038 rst asserted during byte 3 -> outputs reset that cycle, INIT repeated, next start completes normally.
REQ-039 I2C_SEQ_WORD16_EN defined, bytes 0x12,0x34,0x56,0x78,0x9A,0xBC -> word_valid x3 with 0x1234, 0x5678, 0x9ABC.
